// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 chain driver.
// FSM state encodings and the PWM counter width.
package hc595_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int PWM_W = 8;

endpackage

// File: rtl/hc595_clk_div.sv
// Phase tick generator for the 595 driver.
// Ports: clk, rst_n, en (count enable, clears when low),
//        tick (one cycle every CLK_DIV enabled cycles).
module hc595_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/hc595_chain_drv.sv
// Serial driver for CHAIN_N cascaded 74HC595 shift registers.
// Ports: clk, rst_n, load/data (request), busy/done (status),
//        DS/SH_CP/ST_CP (595 pins); with HC595_OE_PWM_EN
//        defined also duty (brightness) and oe_n (output enable).
module hc595_chain_drv
    import hc595_pkg::*;
#(
    parameter int CHAIN_N   = 1,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [8*CHAIN_N-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 DS,
    output logic                 SH_CP,
    output logic                 ST_CP
`ifdef HC595_OE_PWM_EN
    ,
    input  logic [7:0]           duty,
    output logic                 oe_n
`endif
);

    localparam int W  = 8 * CHAIN_N;
    localparam int BW = $clog2(W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   sreg;
    logic [BW-1:0]  bit_cnt;
    logic           tick;
    logic           sh_q;
    logic           st_q;
    logic           ds_q;
    logic           done_q;
    logic           accept;
    logic           bit_end;
    logic           last_bit;
    logic           latch_end;

    hc595_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q != ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A bit ends on the tick closing its SH_CP high half.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        bit_end   = 1'b0;
        last_bit  = 1'b0;
        latch_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick && sh_q) begin
                    bit_end = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        last_bit = 1'b1;
                        state_d  = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    latch_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            sh_q    <= 1'b0;
            st_q    <= 1'b0;
            ds_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= latch_end;
            if (accept) begin
                sreg    <= data;
                bit_cnt <= '0;
                sh_q    <= 1'b0;
                ds_q    <= (MSB_FIRST != 0) ? data[W-1] : data[0];
            end
            if (state_q == ST_SHIFT && tick) begin
                sh_q <= ~sh_q;
            end
            // DS keeps the final bit once the word is out.
            if (bit_end && !last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (MSB_FIRST != 0) begin
                    ds_q <= sreg[W-2];
                    sreg <= {sreg[W-2:0], 1'b0};
                end else begin
                    ds_q <= sreg[1];
                    sreg <= {1'b0, sreg[W-1:1]};
                end
            end
            if (last_bit) begin
                bit_cnt <= '0;
                st_q    <= 1'b1;
            end
            if (latch_end) begin
                st_q <= 1'b0;
            end
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign DS    = ds_q;
    assign SH_CP = sh_q;
    assign ST_CP = st_q;

`ifdef HC595_OE_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;
    logic             oe_q;

    // Full-scale duty forces the outputs on for the whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            oe_q    <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            oe_q    <= ~((duty == 8'hFF) || (pwm_cnt < duty));
        end
    end

    assign oe_n = oe_q;
`endif

endmodule

// File: tb/tb_hc595_chain_drv.sv
// Self-checking bench for hc595_chain_drv (CHAIN_N=2, CLK_DIV=2),
// one MSB-first and one LSB-first instance; PWM under HC595_OE_PWM_EN.
module tb_hc595_chain_drv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_m = 1'b0;
    logic        load_l = 1'b0;
    logic [15:0] data = '0;
    logic        busy_m, done_m, ds_m, sh_m, st_m;
    logic        busy_l, done_l, ds_l, sh_l, st_l;
    logic        sel_l = 1'b0;
    logic        busy, done, ds, sh, st;
    int          checks = 0;
    int          errors = 0;
`ifdef HC595_OE_PWM_EN
    logic [7:0]  duty = '0;
    logic        oe_m, oe_l;
`endif

    always #5 clk = ~clk;

    hc595_chain_drv #(
        .CHAIN_N(2), .CLK_DIV(2), .MSB_FIRST(1)
    ) u_msb (
        .clk(clk), .rst_n(rst_n), .load(load_m), .data(data),
        .busy(busy_m), .done(done_m), .DS(ds_m),
        .SH_CP(sh_m), .ST_CP(st_m)
`ifdef HC595_OE_PWM_EN
        , .duty(duty), .oe_n(oe_m)
`endif
    );

    hc595_chain_drv #(
        .CHAIN_N(2), .CLK_DIV(2), .MSB_FIRST(0)
    ) u_lsb (
        .clk(clk), .rst_n(rst_n), .load(load_l), .data(data),
        .busy(busy_l), .done(done_l), .DS(ds_l),
        .SH_CP(sh_l), .ST_CP(st_l)
`ifdef HC595_OE_PWM_EN
        , .duty(duty), .oe_n(oe_l)
`endif
    );

    assign busy = sel_l ? busy_l : busy_m;
    assign done = sel_l ? done_l : done_m;
    assign ds   = sel_l ? ds_l   : ds_m;
    assign sh   = sel_l ? sh_l   : sh_m;
    assign st   = sel_l ? st_l   : st_m;

    // Bit i of the serial stream as the 595 chain sees it.
    function automatic bit exp_bit(input logic [15:0] d, input bit lsb,
                                   input int i);
        return lsb ? d[i] : d[15-i];
    endfunction

    // Caller is positioned at a negedge. inj: cycle at which a
    // 16'hFFFF load is injected (-1 none). rstb: abort with reset
    // once this many bits were clocked (-1 none).
    task automatic run_xfer(input bit lsb, input logic [15:0] d,
                            input int inj, input int rstb,
                            input bit chk_fall);
        bit got[$];
        int busy_n = 0;
        int st_rise = 0;
        int st_high = 0;
        int bits_at_st = -1;
        bit sh_p = 1'b0;
        bit st_p = 1'b0;
        bit fin = 1'b0;
        bit aborted = 1'b0;
        sel_l = lsb;
        data = d;
        if (lsb) load_l = 1'b1; else load_m = 1'b1;
        @(posedge clk);
        #1;
        load_l = 1'b0;
        load_m = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL accept: busy=%b want 1", busy);
        end
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (c == inj) begin
                data = 16'hFFFF;
                if (lsb) load_l = 1'b1; else load_m = 1'b1;
            end else if (c == inj + 1) begin
                load_l = 1'b0;
                load_m = 1'b0;
            end
            if (sh && !sh_p) got.push_back(ds);
            if (st && !st_p) begin
                st_rise++;
                bits_at_st = got.size();
            end
            if (st) st_high++;
            sh_p = sh;
            st_p = st;
            if (rstb >= 0 && got.size() == rstb) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({busy, done, ds, sh, st} !== 5'b0) begin
                    errors++;
                    $display("FAIL mid_reset: bdDSs=%b want 00000",
                             {busy, done, ds, sh, st});
                end
                aborted = 1'b1;
                fin = 1'b1;
            end else if (busy) begin
                busy_n++;
            end else begin
                fin = 1'b1;
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b want 1", done);
                end
            end
        end
        data = '0;
        if (aborted) begin
            checks++;
            if (st_rise != 0) begin
                errors++;
                $display("FAIL abort_latch: st_cp pulses=%0d want 0",
                         st_rise);
            end
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout: busy never fell");
            return;
        end
        checks++;
        if (got.size() != 16) begin
            errors++;
            $display("FAIL bit_count: got %0d want 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            checks++;
            if (got[i] !== exp_bit(d, lsb, i)) begin
                errors++;
                $display("FAIL ds_bit%0d: got %b want %b (data %h)",
                         i, got[i], exp_bit(d, lsb, i), d);
            end
        end
        checks++;
        if (st_rise != 1 || st_high != 2 || bits_at_st != 16) begin
            errors++;
            $display("FAIL st_cp: pulses=%0d width=%0d at_bit=%0d want 1/2/16",
                     st_rise, st_high, bits_at_st);
        end
        checks++;
        if (busy_n != 66) begin
            errors++;
            $display("FAIL busy_len: got %0d want 66", busy_n);
        end
        checks++;
        if (ds !== exp_bit(d, lsb, 15) || sh !== 1'b0 || st !== 1'b0) begin
            errors++;
            $display("FAIL idle_pins: ds=%b sh=%b st=%b want %b/0/0",
                     ds, sh, st, exp_bit(d, lsb, 15));
        end
        if (chk_fall) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_width: done=%b busy=%b want 0/0",
                         done, busy);
            end
        end
    endtask

    task automatic test_reset();
        int act = 0;
        bit sp, tp;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_m, done_m, ds_m, sh_m, st_m,
             busy_l, done_l, ds_l, sh_l, st_l} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0",
                     {busy_m, done_m, ds_m, sh_m, st_m,
                      busy_l, done_l, ds_l, sh_l, st_l});
        end
`ifdef HC595_OE_PWM_EN
        checks++;
        if ({oe_m, oe_l} !== 2'b11) begin
            errors++;
            $display("FAIL reset_oe: got %b want 11", {oe_m, oe_l});
        end
`endif
        rst_n = 1'b1;
        sp = 1'b0;
        tp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((sh_m | sh_l) || (st_m | st_l) || sp || tp) act++;
            sp = sh_m | sh_l;
            tp = st_m | st_l;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL idle_activity: got %0d active cycles want 0",
                     act);
        end
    endtask

    task automatic test_msb_first();
        @(negedge clk);
        run_xfer(1'b0, 16'hA53C, -1, -1, 1'b1);
    endtask

    task automatic test_lsb_first();
        @(negedge clk);
        run_xfer(1'b1, 16'h0001, -1, -1, 1'b1);
    endtask

    task automatic test_ignore_load();
        @(negedge clk);
        run_xfer(1'b0, 16'hA53C, 20, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        run_xfer(1'b0, 16'hA53C, -1, 7, 1'b0);
        run_xfer(1'b0, 16'hA53C, -1, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        run_xfer(1'b0, a, -1, -1, 1'b0);
        run_xfer(1'b0, b, -1, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            run_xfer(1'($urandom), 16'($urandom), -1, -1, 1'b1);
        end
    endtask

`ifdef HC595_OE_PWM_EN
    task automatic test_pwm();
        logic [7:0] dl[4];
        int low, want;
        dl[0] = 8'h40;
        dl[1] = 8'h00;
        dl[2] = 8'hFF;
        dl[3] = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            duty = dl[k];
            repeat (5) @(negedge clk);
            low = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (oe_m === 1'b0) low++;
            end
            want = (dl[k] == 8'hFF) ? 256 : int'(dl[k]);
            checks++;
            if (low != want) begin
                errors++;
                $display("FAIL pwm_duty%h: low %0d want %0d",
                         dl[k], low, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_ignore_load();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef HC595_OE_PWM_EN
        test_pwm();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
